// File: rtl/s_spi_slave.sv
// SPI mode-0 slave: oversamples SCLK/SS_N/MOSI in the I_CLK domain, shifts one
// DATA_WIDTH frame per chip-select, and exchanges words through a one-entry TX buffer.
module s_spi_slave #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETN,
  input  logic                  I_SCLK,
  input  logic                  I_SS_N,
  input  logic                  I_MOSI,
  output logic                  O_MISO,
  output logic                  O_MISO_OE,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_load,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_frame_err,
  output logic                  o_tx_underrun,
  output logic                  is_receiving
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_WIDTH-1:0] WORD_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic ss_meta_r, ss_sync_r, ss_prev_r;
  logic mosi_meta_r, mosi_sync_r;
  logic sclk_rise_r, sclk_fall_r, ss_fall_r, ss_rise_r;

  state_t state_r, state_nxt;

  logic [DATA_WIDTH-1:0] tx_buf_r;
  logic                  tx_ready_r;
  logic                  consume_s;
  logic                  cnt_full_s;

  logic [DATA_WIDTH-1:0] tx_shift_r, tx_shift_nxt;
  logic [DATA_WIDTH-1:0] rx_shift_r, rx_shift_nxt;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_nxt;
  logic                  miso_r, miso_nxt;
  logic                  miso_oe_r, miso_oe_nxt;
  logic                  recv_r, recv_nxt;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_nxt;
  logic                  rx_valid_r, rx_valid_nxt;
  logic                  frame_err_r, frame_err_nxt;
  logic                  underrun_r, underrun_nxt;

  // Pin synchronizers and registered edge pulses; SS_N flops clear to 0 so a
  // chip-select already low at reset release never produces a falling edge.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      ss_meta_r   <= 1'b0;
      ss_sync_r   <= 1'b0;
      ss_prev_r   <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      ss_fall_r   <= 1'b0;
      ss_rise_r   <= 1'b0;
    end else begin
      sclk_meta_r <= I_SCLK;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      ss_meta_r   <= I_SS_N;
      ss_sync_r   <= ss_meta_r;
      ss_prev_r   <= ss_sync_r;
      mosi_meta_r <= I_MOSI;
      mosi_sync_r <= mosi_meta_r;
      sclk_rise_r <= sclk_sync_r & ~sclk_prev_r;
      sclk_fall_r <= ~sclk_sync_r & sclk_prev_r;
      ss_fall_r   <= ~ss_sync_r & ss_prev_r;
      ss_rise_r   <= ss_sync_r & ~ss_prev_r;
    end
  end

  assign consume_s  = (state_r == ST_IDLE) && ss_fall_r;
  assign cnt_full_s = (bit_cnt_r == CNT_FULL);

  // TX buffer: a load always wins, so a load coinciding with frame start keeps it full.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      tx_buf_r   <= WORD_ZERO;
      tx_ready_r <= 1'b1;
    end else if (i_tx_load) begin
      tx_buf_r   <= i_tx_data;
      tx_ready_r <= 1'b0;
    end else if (consume_s) begin
      tx_ready_r <= 1'b1;
    end else begin
      tx_ready_r <= tx_ready_r;
    end
  end

  // State register.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_r) begin
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (ss_rise_r) begin
          state_nxt = ST_IDLE;
        end else if (cnt_full_s) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (ss_rise_r) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values for each state.
  always_comb begin
    tx_shift_nxt  = tx_shift_r;
    rx_shift_nxt  = rx_shift_r;
    bit_cnt_nxt   = bit_cnt_r;
    miso_nxt      = miso_r;
    miso_oe_nxt   = miso_oe_r;
    recv_nxt      = recv_r;
    rx_data_nxt   = rx_data_r;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    underrun_nxt  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ss_fall_r) begin
          if (tx_ready_r) begin
            tx_shift_nxt = WORD_ZERO;
            miso_nxt     = 1'b0;
            underrun_nxt = 1'b1;
          end else begin
            tx_shift_nxt = tx_buf_r;
            miso_nxt     = tx_buf_r[DATA_WIDTH-1];
          end
          bit_cnt_nxt  = CNT_ZERO;
          rx_shift_nxt = WORD_ZERO;
          miso_oe_nxt  = 1'b1;
          recv_nxt     = 1'b1;
        end else begin
          miso_oe_nxt = 1'b0;
          recv_nxt    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (ss_rise_r) begin
          miso_oe_nxt = 1'b0;
          recv_nxt    = 1'b0;
          if (cnt_full_s) begin
            rx_data_nxt  = rx_shift_r;
            rx_valid_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else if (cnt_full_s) begin
          rx_data_nxt  = rx_shift_r;
          rx_valid_nxt = 1'b1;
        end else if (sclk_rise_r) begin
          rx_shift_nxt = {rx_shift_r[DATA_WIDTH-2:0], mosi_sync_r};
          bit_cnt_nxt  = bit_cnt_r + CNT_ONE;
        end else if (sclk_fall_r) begin
          tx_shift_nxt = {tx_shift_r[DATA_WIDTH-2:0], 1'b0};
          miso_nxt     = tx_shift_r[DATA_WIDTH-2];
        end else begin
          bit_cnt_nxt = bit_cnt_r;
        end
      end
      ST_DONE: begin
        if (ss_rise_r) begin
          miso_oe_nxt = 1'b0;
          recv_nxt    = 1'b0;
        end else begin
          miso_oe_nxt = miso_oe_r;
        end
      end
      default: begin
        miso_oe_nxt = 1'b0;
        recv_nxt    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge I_CLK or negedge I_RESETN) begin
    if (!I_RESETN) begin
      tx_shift_r  <= WORD_ZERO;
      rx_shift_r  <= WORD_ZERO;
      bit_cnt_r   <= CNT_ZERO;
      miso_r      <= 1'b0;
      miso_oe_r   <= 1'b0;
      recv_r      <= 1'b0;
      rx_data_r   <= WORD_ZERO;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      tx_shift_r  <= tx_shift_nxt;
      rx_shift_r  <= rx_shift_nxt;
      bit_cnt_r   <= bit_cnt_nxt;
      miso_r      <= miso_nxt;
      miso_oe_r   <= miso_oe_nxt;
      recv_r      <= recv_nxt;
      rx_data_r   <= rx_data_nxt;
      rx_valid_r  <= rx_valid_nxt;
      frame_err_r <= frame_err_nxt;
      underrun_r  <= underrun_nxt;
    end
  end

  assign O_MISO        = miso_r;
  assign O_MISO_OE     = miso_oe_r;
  assign o_tx_ready    = tx_ready_r;
  assign o_rx_data     = rx_data_r;
  assign o_rx_valid    = rx_valid_r;
  assign o_frame_err   = frame_err_r;
  assign o_tx_underrun = underrun_r;
  assign is_receiving  = recv_r;

endmodule
